// File: rtl/cake_frame_sequencer.sv
// Frame-paced cake animation sequencer: renders the cake, holds it for a number
// of frame ticks, shifts it down one row, erases, and repeats while enabled.
module cake_frame_sequencer #(
    parameter int FRAME_TICKS     = 833333,
    parameter int FRAMES_PER_STEP = 4,
    parameter int DRAW_TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       done_cake,
    input  logic [7:0] x_cake,
    input  logic [6:0] y_cake,
    input  logic [2:0] colour_cake,
    output logic       go_cake,
    output logic       go_shift,
    output logic [7:0] x_vga,
    output logic [6:0] y_vga,
    output logic [2:0] colour_vga,
    output logic       plot,
    output logic [7:0] step_count,
    output logic       error
);

    localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int HW = $clog2(FRAMES_PER_STEP + 1);
    localparam int DW = $clog2(DRAW_TIMEOUT + 1);

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(FRAMES_PER_STEP - 1);
    localparam logic [DW-1:0] DRAW_LAST  = DW'(DRAW_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DRAW,
        HOLD,
        SHIFT,
        ERASE_WAIT,
        ERASE
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] frame_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [DW-1:0] draw_q, draw_d;
    logic [7:0]    step_q, step_d;
    logic          error_q, error_d;
    logic          plot_q, plot_d;
    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic [2:0]    colour_q;
    logic          tick;

    assign tick = (frame_q == FRAME_LAST);

    // Free-running frame timebase, independent of the FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_q <= '0;
        end else if (tick) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_q + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            draw_q   <= '0;
            step_q   <= '0;
            error_q  <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            draw_q   <= draw_d;
            step_q   <= step_d;
            error_q  <= error_d;
            plot_q   <= plot_d;
            x_q      <= x_cake;
            y_q      <= y_cake;
            colour_q <= colour_cake;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        draw_d   = draw_q;
        step_d   = step_q;
        error_d  = error_q;
        plot_d   = 1'b0;
        go_cake  = 1'b0;
        go_shift = 1'b0;
        case (state_q)
            IDLE: begin
                draw_d = '0;
                if (enable && !error_q) state_d = START;
            end
            START: begin
                go_cake = 1'b1;
                draw_d  = '0;
                state_d = DRAW;
            end
            DRAW: begin
                plot_d = !done_cake;
                // done_cake takes priority over a timeout landing in the same cycle.
                if (done_cake) begin
                    hold_d  = '0;
                    state_d = HOLD;
                end else if (draw_q == DRAW_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    draw_d = draw_q + DW'(1);
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) state_d = SHIFT;
                    else                     hold_d  = hold_q + HW'(1);
                end
            end
            SHIFT: begin
                go_shift = 1'b1;
                step_d   = step_q + 8'd1;
                state_d  = ERASE_WAIT;
            end
            ERASE_WAIT: state_d = ERASE;
            ERASE: begin
                plot_d  = 1'b1;
                state_d = enable ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign x_vga      = x_q;
    assign y_vga      = y_q;
    assign colour_vga = colour_q;
    assign plot       = plot_q;
    assign step_count = step_q;
    assign error      = error_q;

endmodule

// File: tb/tb_cake_frame_sequencer.sv
// Directed bench for cake_frame_sequencer with short frame/hold/timeout settings.
module tb_cake_frame_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       done_cake = 1'b0;
    logic [7:0] x_cake = 8'h00;
    logic [6:0] y_cake = 7'h00;
    logic [2:0] colour_cake = 3'h0;
    logic       go_cake, go_shift, plot, error;
    logic [7:0] x_vga, step_count;
    logic [6:0] y_vga;
    logic [2:0] colour_vga;

    int checks = 0;
    int errors = 0;

    cake_frame_sequencer #(
        .FRAME_TICKS(4), .FRAMES_PER_STEP(2), .DRAW_TIMEOUT(10)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .done_cake(done_cake),
        .x_cake(x_cake), .y_cake(y_cake), .colour_cake(colour_cake),
        .go_cake(go_cake), .go_shift(go_shift), .x_vga(x_vga), .y_vga(y_vga),
        .colour_vga(colour_vga), .plot(plot), .step_count(step_count), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; enable = 1'b0; done_cake = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; x_cake = 8'hFF; y_cake = 7'h7F; colour_cake = 3'h7; enable = 1'b1;
        step();
        step();
        checks++; if ({go_cake, go_shift, plot, error} !== 4'b0) begin errors++;
            $display("FAIL reset_flags: got %b exp 0000", {go_cake, go_shift, plot, error}); end
        checks++; if ({x_vga, y_vga, colour_vga} !== 18'h0) begin errors++;
            $display("FAIL reset_pixel: got %h exp 0", {x_vga, y_vga, colour_vga}); end
        checks++; if (step_count !== 8'd0) begin errors++;
            $display("FAIL reset_step_count: got %0d exp 0", step_count); end
        enable = 1'b0;
    endtask

    task automatic test_draw_shift();
        int n;
        do_reset();
        enable = 1'b1; x_cake = 8'h11; y_cake = 7'h22; colour_cake = 3'h5;
        step();
        checks++; if (go_cake !== 1'b1 || plot !== 1'b0) begin errors++;
            $display("FAIL start_go_cake: got go=%b plot=%b exp go=1 plot=0", go_cake, plot); end
        checks++; if ({x_vga, y_vga, colour_vga} !== {8'h11, 7'h22, 3'h5}) begin errors++;
            $display("FAIL pixel_copy: got %h exp %h", {x_vga, y_vga, colour_vga}, {8'h11, 7'h22, 3'h5}); end
        x_cake = 8'h20;
        step();
        checks++; if (go_cake !== 1'b0 || plot !== 1'b0 || x_vga !== 8'h20) begin errors++;
            $display("FAIL draw_entry: got go=%b plot=%b x=%h exp 0 0 20", go_cake, plot, x_vga); end
        for (int k = 3; k <= 6; k++) begin
            x_cake = 8'h20 + 8'(k);
            step();
            checks++; if (plot !== 1'b1 || x_vga !== 8'h20 + 8'(k)) begin errors++;
                $display("FAIL draw_plot_%0d: got plot=%b x=%h exp 1 %h", k, plot, x_vga, 8'h20 + 8'(k)); end
        end
        done_cake = 1'b1;
        step();
        done_cake = 1'b0;
        checks++; if (plot !== 1'b0) begin errors++;
            $display("FAIL done_plot: got %b exp 0", plot); end
        n = 0;
        while (go_shift !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (go_shift !== 1'b1 || n < 5 || n > 8) begin errors++;
            $display("FAIL hold_length: got go_shift=%b after %0d cycles exp 1 after 5..8", go_shift, n); end
        checks++; if (step_count !== 8'd0 || plot !== 1'b0) begin errors++;
            $display("FAIL shift_cycle: got step=%0d plot=%b exp 0 0", step_count, plot); end
        step();
        checks++; if (go_shift !== 1'b0 || step_count !== 8'd1 || plot !== 1'b0) begin errors++;
            $display("FAIL after_shift: got gs=%b step=%0d plot=%b exp 0 1 0", go_shift, step_count, plot); end
        step();
        checks++; if (plot !== 1'b0) begin errors++;
            $display("FAIL erase_wait_plot: got %b exp 0", plot); end
        step();
        checks++; if (plot !== 1'b1 || go_cake !== 1'b1) begin errors++;
            $display("FAIL erase_plot: got plot=%b go=%b exp 1 1", plot, go_cake); end
        step();
        checks++; if (plot !== 1'b0 || go_cake !== 1'b0) begin errors++;
            $display("FAIL erase_done: got plot=%b go=%b exp 0 0", plot, go_cake); end
        enable = 1'b0;
    endtask

    task automatic test_timeout();
        int gc;
        do_reset();
        enable = 1'b1;
        step();
        checks++; if (go_cake !== 1'b1) begin errors++;
            $display("FAIL timeout_start: got %b exp 1", go_cake); end
        done_cake = 1'b1;   // seen in START, must be ignored
        step();
        done_cake = 1'b0;
        for (int k = 0; k < 9; k++) step();
        checks++; if (error !== 1'b0) begin errors++;
            $display("FAIL timeout_early: got error=%b exp 0", error); end
        step();
        checks++; if (error !== 1'b1 || plot !== 1'b1) begin errors++;
            $display("FAIL timeout_set: got error=%b plot=%b exp 1 1", error, plot); end
        step();
        checks++; if (plot !== 1'b0) begin errors++;
            $display("FAIL timeout_plot: got %b exp 0", plot); end
        gc = 0;
        for (int k = 0; k < 20; k++) begin step(); if (go_cake === 1'b1) gc++; end
        checks++; if (gc !== 0 || error !== 1'b1) begin errors++;
            $display("FAIL timeout_idle: got go_cake count=%0d error=%b exp 0 1", gc, error); end
        enable = 1'b0;
    endtask

    task automatic test_done_timeout_tie();
        int n;
        do_reset();
        enable = 1'b1;
        step();
        step();
        for (int k = 0; k < 9; k++) step();
        done_cake = 1'b1;
        step();
        done_cake = 1'b0;
        checks++; if (error !== 1'b0) begin errors++;
            $display("FAIL tie_error: got %b exp 0", error); end
        n = 0;
        while (go_shift !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (go_shift !== 1'b1) begin errors++;
            $display("FAIL tie_shift: got go_shift=%b after %0d cycles exp 1", go_shift, n); end
        step();
        checks++; if (step_count !== 8'd1) begin errors++;
            $display("FAIL tie_step: got %0d exp 1", step_count); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop_tick();
        int gs, gc;
        do_reset();
        enable = 1'b1;
        step();
        for (int k = 0; k < 5; k++) step();
        done_cake = 1'b1;
        step();
        done_cake = 1'b0;
        for (int k = 0; k < 4; k++) step();
        enable = 1'b0;      // this HOLD cycle carries the second tick
        step();
        checks++; if (go_shift !== 1'b0) begin errors++;
            $display("FAIL drop_go_shift: got %b exp 0", go_shift); end
        gs = 0; gc = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (go_shift === 1'b1) gs++;
            if (go_cake === 1'b1) gc++;
        end
        checks++; if (gs !== 0 || gc !== 0 || step_count !== 8'd0) begin errors++;
            $display("FAIL drop_quiet: got gs=%0d gc=%0d step=%0d exp 0 0 0", gs, gc, step_count); end
        enable = 1'b1;
        step();
        checks++; if (go_cake !== 1'b1) begin errors++;
            $display("FAIL drop_idle_restart: got %b exp 1", go_cake); end
        enable = 1'b0;
    endtask

    task automatic test_wrap();
        int shifts, overlap, cyc;
        do_reset();
        enable = 1'b1; done_cake = 1'b1;
        shifts = 0; overlap = 0; cyc = 0;
        while (shifts < 256 && cyc < 20000) begin
            step();
            cyc++;
            if (go_cake === 1'b1 && go_shift === 1'b1) overlap++;
            if (go_shift === 1'b1) shifts++;
        end
        checks++; if (shifts !== 256) begin errors++;
            $display("FAIL wrap_shifts: got %0d exp 256", shifts); end
        checks++; if (step_count !== 8'd255) begin errors++;
            $display("FAIL wrap_pre: got %0d exp 255", step_count); end
        step();
        checks++; if (step_count !== 8'd0) begin errors++;
            $display("FAIL wrap_zero: got %0d exp 0", step_count); end
        checks++; if (overlap !== 0) begin errors++;
            $display("FAIL go_overlap: got %0d exp 0", overlap); end
        enable = 1'b0; done_cake = 1'b0;
    endtask

    task automatic test_reset_mid_draw();
        int n;
        do_reset();
        enable = 1'b1; done_cake = 1'b1;
        x_cake = 8'h5A; y_cake = 7'h33; colour_cake = 3'h6;
        n = 0;
        while (go_shift !== 1'b1 && n < 30) begin step(); n++; end
        done_cake = 1'b0;
        n = 0;
        while (go_cake !== 1'b1 && n < 10) begin step(); n++; end
        step();
        step();
        checks++; if (plot !== 1'b1 || step_count !== 8'd1 || x_vga !== 8'h5A) begin errors++;
            $display("FAIL mid_draw_pre: got plot=%b step=%0d x=%h exp 1 1 5a", plot, step_count, x_vga); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({go_cake, go_shift, plot, error} !== 4'b0 || step_count !== 8'd0) begin errors++;
            $display("FAIL async_flags: got %b step=%0d exp 0000 0", {go_cake, go_shift, plot, error}, step_count); end
        checks++; if ({x_vga, y_vga, colour_vga} !== 18'h0) begin errors++;
            $display("FAIL async_pixel: got %h exp 0", {x_vga, y_vga, colour_vga}); end
        step();
        resetn = 1'b1;
        checks++; if (go_cake !== 1'b0) begin errors++;
            $display("FAIL release_idle: got %b exp 0", go_cake); end
        step();
        checks++; if (go_cake !== 1'b1) begin errors++;
            $display("FAIL release_start: got %b exp 1", go_cake); end
        step();
        checks++; if (go_cake !== 1'b0 || plot !== 1'b0) begin errors++;
            $display("FAIL release_draw: got go=%b plot=%b exp 0 0", go_cake, plot); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_draw_shift();
        test_timeout();
        test_done_timeout_tie();
        test_enable_drop_tick();
        test_wrap();
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cake_frame_sequencer.md
CAKE_FRAME_SEQUENCER -- requirements
Module: cake_frame_sequencer

Interface
REQ-001 Parameter FRAME_TICKS, default 833333; clk cycles per frame tick (50 MHz / 60 Hz).
REQ-002 Parameter FRAMES_PER_STEP, default 4; frame ticks between cake shifts.
REQ-003 Parameter DRAW_TIMEOUT, default 255; max DRAW cycles without done_cake.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  game running; level.
REQ-008 done_cake  in  1  renderer finished drawing the cake image.
REQ-009 x_cake  in  8  renderer pixel x.
REQ-010 y_cake  in  7  renderer pixel y.
REQ-011 colour_cake  in  3  renderer pixel colour.
REQ-012 go_cake  out  1  one-cycle pulse that starts a render.
REQ-013 go_shift  out  1  one-cycle pulse that moves the cake down one row.
REQ-014 x_vga  out  8  pixel x to the VGA adapter.
REQ-015 y_vga  out  7  pixel y to the VGA adapter.
REQ-016 colour_vga  out  3  pixel colour to the VGA adapter.
REQ-017 plot  out  1  VGA write enable.
REQ-018 step_count  out  8  number of completed shifts; wraps 255->0.
REQ-019 error  out  1  sticky flag for draw timeout.

Function
REQ-020 The FSM SHALL have the states IDLE, START, DRAW, HOLD, SHIFT, ERASE_WAIT and ERASE.
REQ-021 IDLE -> START when enable=1 and error=0; otherwise stay in IDLE.
REQ-022 START: go_cake=1 for exactly one cycle, then DRAW.
REQ-023 DRAW: stay until done_cake=1, then HOLD; enable is ignored in DRAW.
REQ-024 DRAW timeout: if the DRAW cycle count reaches DRAW_TIMEOUT without done_cake, set error=1 and go to IDLE.
REQ-025 HOLD: if enable=0, go to IDLE; otherwise go to SHIFT on the frame tick that brings the HOLD tick count to FRAMES_PER_STEP.
REQ-026 The HOLD tick count SHALL clear on entry to HOLD.
REQ-027 SHIFT: go_shift=1 for one cycle; step_count increments by 1; then ERASE_WAIT.
REQ-028 ERASE_WAIT: one cycle with no outputs, then ERASE.
REQ-029 ERASE: plot asserted for the renderer's black pixel; next state is START if enable=1, else IDLE.
REQ-030 Frame tick counter: free-running 0..FRAME_TICKS-1; the tick pulse is high for one cycle when the count equals FRAME_TICKS-1, and the count then wraps to 0.
REQ-031 x_vga, y_vga and colour_vga SHALL be registered copies of x_cake, y_cake and colour_cake (1-cycle latency), updated every cycle.
REQ-032 plot SHALL be registered: plot(t+1)=1 iff the state at t is DRAW (excluding the cycle done_cake is seen) or ERASE.
REQ-033 At most one of go_cake and go_shift SHALL be high in any cycle; neither SHALL be high outside START and SHIFT respectively.
REQ-034 A done_cake pulse seen outside DRAW SHALL be ignored.
REQ-035 If done_cake and the timeout condition occur in the same cycle, done_cake SHALL win (go to HOLD, error unchanged).
REQ-036 If the frame tick and enable=0 occur in the same HOLD cycle, the block SHALL go to IDLE with no shift.
REQ-037 Counter widths SHALL be sized by $clog2 of their parameters; no truncation is allowed.

Reset
REQ-038 resetn=0 SHALL force, asynchronously: state IDLE, all counters 0, go_cake=0, go_shift=0, plot=0, x_vga=0, y_vga=0, colour_vga=0, step_count=0, error=0.
REQ-039 Reset asserted mid-DRAW or mid-HOLD SHALL abort immediately; after release the block restarts from IDLE, and the first go_cake SHALL come no earlier than 1 cycle after enable is seen.
REQ-040 error SHALL clear only on reset.

Verification (FRAME_TICKS=4, FRAMES_PER_STEP=2, DRAW_TIMEOUT=10)
REQ-041 Reset release, enable=1 -> go_cake pulses 1 cycle; state DRAW; plot=0 before DRAW.
REQ-042 done_cake high 5 cycles after go_cake -> plot high for DRAW cycles; x_vga equals x_cake from 1 cycle earlier; HOLD lasts 2 ticks (5-8 cycles) -> go_shift 1 cycle, step_count=1, plot high 2 cycles later for 1 cycle.
REQ-043 done_cake never asserted -> error=1 after 10 DRAW cycles; state IDLE; no further go_cake while enable stays 1.
REQ-044 enable dropped during HOLD coincident with a tick -> no go_shift; step_count unchanged; state IDLE.
REQ-045 256 full shift cycles -> step_count wraps to 0; go_cake and go_shift never overlap.
REQ-046 resetn pulsed low mid-DRAW -> all outputs 0 in the same cycle (async); normal START after release.
